// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned WORD_LEN = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_MEM = 2'd1,
    BUS_IF  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                we;
    logic [WORD_LEN-1:0] addr;
    logic [WORD_LEN-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Bus watchdog: down-counter loaded at grant, terminal count at zero.
module arb_timeout_ctr #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory bus between instruction fetch and the MEM
// stage, with MEM-streak fairness, a bus watchdog and pipeline stall generation.
//
// state   | meaning
// IDLE    | no access outstanding; arbitrate unless a done pulse is showing
// BUS_MEM | MEM-stage load/store on the bus, waiting for ack or timeout
// BUS_IF  | instruction fetch on the bus, waiting for ack or timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_MEM_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                mem_r_en_in,
  input  logic                mem_w_en_in,
  input  logic [WORD_LEN-1:0] mem_addr_in,
  input  logic [WORD_LEN-1:0] mem_wdata_in,
  output logic [WORD_LEN-1:0] mem_rdata_out,
  output logic                mem_done,
  input  logic                if_req,
  input  logic [WORD_LEN-1:0] if_addr,
  output logic [WORD_LEN-1:0] if_rdata,
  output logic                if_done,
  output logic                bus_req,
  output logic                bus_we,
  output logic [WORD_LEN-1:0] bus_addr,
  output logic [WORD_LEN-1:0] bus_wdata,
  input  logic [WORD_LEN-1:0] bus_rdata,
  input  logic                bus_ack,
  output logic                stall_pipe,
  output logic                stall_if,
  output logic                timeout_err
);

  localparam int unsigned ST_W = $clog2(MAX_MEM_STREAK + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ST_W-1:0] STREAK_MAX = ST_W'(MAX_MEM_STREAK);

  arb_state_t          state, state_nxt;
  bus_req_t            bus_q, bus_nxt;
  logic                req_nxt, mem_done_nxt, if_done_nxt, terr_nxt;
  logic [WORD_LEN-1:0] mem_rdata_nxt, if_rdata_nxt;
  logic [ST_W-1:0]     streak, streak_nxt;
  logic                ctr_load, ctr_tc;
  logic                mem_any, if_force;

  assign mem_any  = mem_r_en_in | mem_w_en_in;
  assign if_force = if_req && (streak == STREAK_MAX);

  arb_timeout_ctr #(.WIDTH(TO_W)) u_timeout (
    .clk      (clk),
    .rstn     (rstn),
    .load     (ctr_load),
    .en       (state != IDLE),
    .load_val (TO_W'(TIMEOUT_CYCLES - 1)),
    .tc       (ctr_tc)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      bus_q         <= '0;
      bus_req       <= 1'b0;
      mem_done      <= 1'b0;
      if_done       <= 1'b0;
      mem_rdata_out <= '0;
      if_rdata      <= '0;
      timeout_err   <= 1'b0;
      streak        <= '0;
    end else begin
      state         <= state_nxt;
      bus_q         <= bus_nxt;
      bus_req       <= req_nxt;
      mem_done      <= mem_done_nxt;
      if_done       <= if_done_nxt;
      mem_rdata_out <= mem_rdata_nxt;
      if_rdata      <= if_rdata_nxt;
      timeout_err   <= terr_nxt;
      streak        <= streak_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus_nxt       = bus_q;
    req_nxt       = bus_req;
    mem_done_nxt  = 1'b0;
    if_done_nxt   = 1'b0;
    mem_rdata_nxt = mem_rdata_out;
    if_rdata_nxt  = if_rdata;
    terr_nxt      = timeout_err;
    streak_nxt    = streak;
    ctr_load      = 1'b0;
    unique case (state)
      IDLE: begin
        // The done cycle is the pipeline's turnaround; its requests are stale.
        if (!(mem_done || if_done)) begin
          if (mem_any && !if_force) begin
            state_nxt  = BUS_MEM;
            req_nxt    = 1'b1;
            bus_nxt    = '{we: mem_w_en_in, addr: mem_addr_in, wdata: mem_wdata_in};
            ctr_load   = 1'b1;
            if (!if_req)                   streak_nxt = '0;
            else if (streak != STREAK_MAX) streak_nxt = streak + ST_W'(1);
          end else if (if_req) begin
            state_nxt  = BUS_IF;
            req_nxt    = 1'b1;
            bus_nxt    = '{we: 1'b0, addr: if_addr, wdata: '0};
            ctr_load   = 1'b1;
            streak_nxt = '0;
          end
        end
      end
      BUS_MEM, BUS_IF: begin
        if (bus_ack || ctr_tc) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          if (!bus_ack) terr_nxt = 1'b1;
          if (state == BUS_MEM) begin
            mem_done_nxt  = 1'b1;
            mem_rdata_nxt = (bus_ack && !bus_q.we) ? bus_rdata : '0;
          end else begin
            if_done_nxt  = 1'b1;
            if_rdata_nxt = bus_ack ? bus_rdata : '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus_we     = bus_q.we;
  assign bus_addr   = bus_q.addr;
  assign bus_wdata  = bus_q.wdata;
  assign stall_pipe = mem_any & ~mem_done;
  assign stall_if   = stall_pipe | (if_req & ~if_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  logic mem_r_en_in, mem_w_en_in, if_req, bus_ack;
  logic [WORD_LEN-1:0] mem_addr_in, mem_wdata_in, if_addr, bus_rdata;
  logic [WORD_LEN-1:0] mem_rdata_out, if_rdata, bus_addr, bus_wdata;
  logic mem_done, if_done, bus_req, bus_we, stall_pipe, stall_if, timeout_err;

  int checks = 0;
  int errors = 0;

  // bus responder: ack after ack_lat cycles of bus_req (0 = never)
  logic resp_en = 1'b0;
  int   ack_lat = 1;
  int   rcnt = 0;
  logic [WORD_LEN-1:0] resp_data = '0;

  // grant log
  logic req_prev = 1'b0;
  logic g_we[$];
  logic [WORD_LEN-1:0] g_addr[$];
  logic [WORD_LEN-1:0] g_wdata[$];

  mem_port_arbiter dut (
    .clk(clk), .rstn(rstn),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
    .mem_rdata_out(mem_rdata_out), .mem_done(mem_done),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stall_pipe(stall_pipe), .stall_if(stall_if), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (resp_en) begin
      if (bus_req) begin
        rcnt++;
        bus_ack   = (rcnt == ack_lat);
        bus_rdata = resp_data;
      end else begin
        rcnt    = 0;
        bus_ack = 1'b0;
      end
    end
    if (bus_req && !req_prev) begin
      g_we.push_back(bus_we);
      g_addr.push_back(bus_addr);
      g_wdata.push_back(bus_wdata);
    end
    req_prev = bus_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors %0d", errors);
    $fatal(1, "global timeout");
  end

  task automatic clear_log();
    g_we.delete(); g_addr.delete(); g_wdata.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; mem_r_en_in = 0; mem_w_en_in = 0; if_req = 0; bus_ack = 0;
    mem_addr_in = '0; mem_wdata_in = '0; if_addr = '0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if ({bus_req, bus_we, mem_done, if_done, timeout_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {bus_req, bus_we, mem_done, if_done, timeout_err}); end
    checks++; if ({bus_addr, bus_wdata, mem_rdata_out, if_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {bus_addr, bus_wdata, mem_rdata_out, if_rdata}); end
    checks++; if ({stall_pipe, stall_if} !== 2'b00) begin
      errors++; $display("FAIL reset_stall: got %b expected 00", {stall_pipe, stall_if}); end
    rstn = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    bus_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if ({bus_req, mem_done, if_done} !== 3'b000) begin
        errors++; $display("FAIL stray_ack: got %b expected 000", {bus_req, mem_done, if_done}); end
    end
  endtask

  task automatic test_mem_load();
    int hi = 0; bit got = 0;
    resp_en = 1; ack_lat = 3; resp_data = 32'hDEADBEEF; clear_log();
    mem_r_en_in = 1; mem_addr_in = 32'h100;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1; break; end
      if (bus_req) hi++;
      checks++; if (stall_pipe !== 1'b1) begin
        errors++; $display("FAIL load_stall: got %b expected 1", stall_pipe); end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL load_done: got %b expected 1", got); end
    checks++; if (hi != 3) begin errors++; $display("FAIL load_req_len: got %0d expected 3", hi); end
    checks++; if (mem_rdata_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_rdata: got %h expected deadbeef", mem_rdata_out); end
    checks++; if ({stall_pipe, bus_req} !== 2'b00) begin
      errors++; $display("FAIL load_done_cycle: got %b expected 00", {stall_pipe, bus_req}); end
    checks++; if (g_addr.size() != 1 || g_addr[0] !== 32'h100 || g_we[0] !== 1'b0) begin
      errors++; $display("FAIL load_grant: got %0d grants expected 1 at 100 read", g_addr.size()); end
    mem_r_en_in = 0;
    @(negedge clk);
    checks++; if ({mem_done, bus_req} !== 2'b00) begin
      errors++; $display("FAIL load_pulse: got %b expected 00", {mem_done, bus_req}); end
  endtask

  task automatic test_if_and_store();
    bit got = 0;
    resp_en = 1; ack_lat = 2; resp_data = 32'hCAFE0040; clear_log();
    if_req = 1; if_addr = 32'h40;
    mem_w_en_in = 1; mem_addr_in = 32'h200; mem_wdata_in = 32'h12345678;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1; break; end
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL store_done: got %b expected 1", got); end
    checks++; if (mem_rdata_out !== 32'h0) begin
      errors++; $display("FAIL store_rdata: got %h expected 0", mem_rdata_out); end
    checks++; if ({stall_pipe, stall_if} !== 2'b01) begin
      errors++; $display("FAIL store_stalls: got %b expected 01", {stall_pipe, stall_if}); end
    mem_w_en_in = 0;
    @(negedge clk);
    checks++; if ({bus_req, stall_if} !== 2'b01) begin
      errors++; $display("FAIL fetch_gap: got %b expected 01", {bus_req, stall_if}); end
    @(negedge clk);
    checks++; if ({bus_req, bus_we, bus_addr} !== {2'b10, 32'h40}) begin
      errors++; $display("FAIL fetch_issue: got %b %b %h expected 1 0 40", bus_req, bus_we, bus_addr); end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (if_done) begin got = 1; break; end
      checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b expected 1", stall_if); end
      @(negedge clk);
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL fetch_done: got %b expected 1", got); end
    checks++; if ({if_rdata, stall_if} !== {32'hCAFE0040, 1'b0}) begin
      errors++; $display("FAIL fetch_rdata: got %h/%b expected cafe0040/0", if_rdata, stall_if); end
    if_req = 0;
    checks++; if (g_we.size() != 2 || g_we[0] !== 1'b1 || g_addr[0] !== 32'h200 || g_wdata[0] !== 32'h12345678
                  || g_we[1] !== 1'b0 || g_addr[1] !== 32'h40) begin
      errors++; $display("FAIL order: got %0d grants, first we %b addr %h wdata %h expected store 200/12345678 then fetch 40",
                         g_we.size(), g_we[0], g_addr[0], g_wdata[0]); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    int nmem = 0, nif = 0;
    logic [WORD_LEN-1:0] exp_addr [6];
    exp_addr[0] = 32'h300; exp_addr[1] = 32'h300; exp_addr[2] = 32'h300;
    exp_addr[3] = 32'h300; exp_addr[4] = 32'h80;  exp_addr[5] = 32'h300;
    resp_en = 1; ack_lat = 1; resp_data = 32'h55AA55AA; clear_log();
    if_req = 1; if_addr = 32'h80; mem_r_en_in = 1; mem_addr_in = 32'h300;
    for (int i = 0; i < 100 && nmem < 5; i++) begin
      @(negedge clk);
      if (mem_done) nmem++;
      if (if_done) nif++;
    end
    mem_r_en_in = 0; if_req = 0;
    checks++; if (nmem != 5 || nif != 1) begin
      errors++; $display("FAIL fair_counts: got mem %0d if %0d expected 5 1", nmem, nif); end
    checks++; if (g_addr.size() != 6) begin
      errors++; $display("FAIL fair_grants: got %0d expected 6", g_addr.size()); end
    for (int i = 0; i < 6 && i < g_addr.size(); i++) begin
      checks++; if (g_addr[i] !== exp_addr[i]) begin
        errors++; $display("FAIL fair_seq[%0d]: got %h expected %h", i, g_addr[i], exp_addr[i]); end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi = 0; bit got = 0;
    resp_en = 1; ack_lat = 0; clear_log();
    mem_r_en_in = 1; mem_addr_in = 32'h400;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1; break; end
      if (bus_req) hi++;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL to_done: got %b expected 1", got); end
    checks++; if (hi != 64) begin errors++; $display("FAIL to_len: got %0d expected 64", hi); end
    checks++; if ({mem_rdata_out, timeout_err, bus_req} !== {32'h0, 2'b10}) begin
      errors++; $display("FAIL to_result: got %h %b %b expected 0 1 0", mem_rdata_out, timeout_err, bus_req); end
    mem_r_en_in = 0;
    @(negedge clk);
    ack_lat = 1; resp_data = 32'h0BADF00D;
    mem_r_en_in = 1; mem_addr_in = 32'h404; got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1; break; end
    end
    mem_r_en_in = 0;
    checks++; if ({got, timeout_err, mem_rdata_out} !== {2'b11, 32'h0BADF00D}) begin
      errors++; $display("FAIL to_sticky: got %b %b %h expected 1 1 0badf00d", got, timeout_err, mem_rdata_out); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got = 0; int dones = 0;
    resp_en = 0; bus_ack = 0; clear_log();
    mem_w_en_in = 1; mem_addr_in = 32'h500; mem_wdata_in = 32'hAAAA5555;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_req) begin got = 1; break; end
    end
    checks++; if ({got, bus_we} !== 2'b11) begin errors++; $display("FAIL rst_mid_req: got %b expected 11", {got, bus_we}); end
    rstn = 0; mem_w_en_in = 0;
    @(negedge clk);
    checks++; if ({bus_req, bus_we, mem_done, if_done, timeout_err} !== 5'b0 || {bus_addr, bus_wdata, mem_rdata_out} !== '0) begin
      errors++; $display("FAIL rst_mid_clear: got %b %h expected all 0", {bus_req, bus_we, mem_done, if_done, timeout_err}, bus_addr); end
    rstn = 1; bus_ack = 1; bus_rdata = 32'h77777777;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_ack = 0;
      if (mem_done || if_done || bus_req) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_late_ack: got %0d activity cycles expected 0", dones); end
  endtask

  task automatic test_turnaround();
    bit got = 0;
    resp_en = 1; ack_lat = 2; resp_data = 32'h600D600D; clear_log();
    mem_r_en_in = 1; mem_addr_in = 32'h600;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1; break; end
    end
    checks++; if ({got, bus_req} !== 2'b10) begin errors++; $display("FAIL ta_done: got %b expected 10", {got, bus_req}); end
    @(negedge clk);
    checks++; if ({mem_done, bus_req} !== 2'b00) begin
      errors++; $display("FAIL ta_no_dup: got %b expected 00", {mem_done, bus_req}); end
    @(negedge clk);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL ta_regrant: got %b expected 1", bus_req); end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1; break; end
    end
    mem_r_en_in = 0;
    checks++; if (got !== 1'b1 || g_addr.size() != 2) begin
      errors++; $display("FAIL ta_grants: got done %b grants %0d expected 1 2", got, g_addr.size()); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mem_load();
    test_if_and_store();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_turnaround();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
